// File: rtl/pc_unit_defs.sv
// Shared state encoding and exception codes for the PC update unit and control unit.
// Constants only: no latency and no backpressure apply.
// The control unit imports the same exception code constants.
package pc_unit_defs;

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] VEC_REQ  = 2'd1;
   localparam logic [1:0] VEC_WAIT = 2'd2;
   localparam logic [1:0] VEC_LOAD = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = RUN,
      ST_VEC_REQ  = VEC_REQ,
      ST_VEC_WAIT = VEC_WAIT,
      ST_VEC_LOAD = VEC_LOAD
   } pc_state_t;

   typedef logic [1:0] exc_code_t;

   localparam exc_code_t EXC_BAD_OPCODE = 2'd0;
   localparam exc_code_t EXC_OVERFLOW   = 2'd1;
   localparam exc_code_t EXC_DIV_ZERO   = 2'd2;
   localparam exc_code_t EXC_RESERVED   = 2'd3;

endpackage

// File: rtl/pc_src_mux_n.sv
// Generic N x W channel selector with an out-of-range flag.
// Purely combinational, zero latency.
// No backpressure; the output is zero when sel selects no channel.
module pc_src_mux_n #(
   parameter  int N     = 4,
   parameter  int W     = 32,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   data,
   output logic [W-1:0]     out,
   output logic             oor
);

   always_comb begin
      out = '0;
      oor = (int'(sel) >= N);
      for (int k = 0; k < N; k++) begin
         if (sel == SEL_W'(k)) out = data[k*W +: W];
      end
   end

endmodule

// File: rtl/pc_update_unit.sv
// Program counter update: channel-selected loads plus the exception vector entry sequence.
// Normal load latency 1; an exception holds the unit busy for MEM_LAT+1 cycles before the handler PC appears.
// No backpressure: loads and exception requests arriving while busy are dropped.
module pc_update_unit
   import pc_unit_defs::*;
#(
   parameter  int                WIDTH    = 32,
   parameter  int                NSRC     = 4,
   parameter  logic [WIDTH-1:0]  RESET_PC = '0,
   parameter  int unsigned       VEC_BASE = 253,
   parameter  int                MEM_LAT  = 1,
   localparam int                SEL_W    = $clog2(NSRC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SEL_W-1:0]      src_sel,
   input  logic [NSRC*WIDTH-1:0] src_data,
   input  logic                  pc_write,
   input  logic                  pc_write_cond,
   input  logic                  zero,
   input  logic                  exc_req,
   input  logic [1:0]            exc_code,
   input  logic [7:0]            vec_data,
   output logic                  vec_rd,
   output logic [WIDTH-1:0]      vec_addr,
   output logic [WIDTH-1:0]      pc,
   output logic [WIDTH-1:0]      epc,
   output logic                  exc_busy,
   output logic                  exc_done
);

   localparam int CNT_W     = $clog2(MEM_LAT + 1);
   localparam int WAIT_LAST = (MEM_LAT >= 2) ? MEM_LAT - 2 : 0;

   pc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   exc_code_t        code_q;
   logic [WIDTH-1:0] pc_q, epc_q;
   logic             done_q;

   logic [WIDTH-1:0] mux_out;
   logic             mux_oor;
   logic             load;

   pc_src_mux_n #(
      .N (NSRC),
      .W (WIDTH)
   ) u_src_mux (
      .sel  (src_sel),
      .data (src_data),
      .out  (mux_out),
      .oor  (mux_oor)
   );

   assign load = pc_write | (pc_write_cond & zero);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (exc_req) state_d = ST_VEC_REQ;
         end
         ST_VEC_REQ: begin
            cnt_d   = '0;
            // With single-cycle memory the data is already due next cycle
            state_d = (MEM_LAT == 1) ? ST_VEC_LOAD : ST_VEC_WAIT;
         end
         ST_VEC_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WAIT_LAST)) state_d = ST_VEC_LOAD;
         end
         ST_VEC_LOAD: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         code_q  <= EXC_BAD_OPCODE;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= (state_q == ST_VEC_LOAD);
         if (state_q == ST_RUN) begin
            // Exception entry takes priority over a same-cycle load
            if (exc_req) begin
               epc_q  <= pc_q - WIDTH'(4);
               code_q <= exc_code;
            end else if (load && !mux_oor) begin
               pc_q <= mux_out;
            end
         end else if (state_q == ST_VEC_LOAD) begin
            pc_q <= WIDTH'(vec_data);
         end
      end
   end

   assign vec_rd   = (state_q == ST_VEC_REQ);
   assign vec_addr = vec_rd ? (WIDTH'(VEC_BASE) + WIDTH'(code_q)) : '0;
   assign pc       = pc_q;
   assign epc      = epc_q;
   assign exc_busy = (state_q != ST_RUN);
   assign exc_done = done_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Bench for pc_update_unit: directed table on a default build, hand sequences on a
// NSRC=5/MEM_LAT=3/RESET_PC=0x100 build, then random traffic against a cycle model.
module tb_pc_update_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Build A: defaults (NSRC=4, MEM_LAT=1, RESET_PC=0)
   logic         a_rst, a_pw, a_pwc, a_zero, a_exc;
   logic [1:0]   a_sel, a_code;
   logic [127:0] a_src;
   logic [7:0]   a_vdata;
   logic         a_vrd, a_busy, a_done;
   logic [31:0]  a_vaddr, a_pc, a_epc;

   // Build B: NSRC=5, MEM_LAT=3, RESET_PC=0x100
   logic         b_rst, b_pw, b_pwc, b_zero, b_exc;
   logic [2:0]   b_sel;
   logic [1:0]   b_code;
   logic [159:0] b_src;
   logic [7:0]   b_vdata;
   logic         b_vrd, b_busy, b_done;
   logic [31:0]  b_vaddr, b_pc, b_epc;

   pc_update_unit dut_a (
      .clk(clk), .reset(a_rst), .src_sel(a_sel), .src_data(a_src),
      .pc_write(a_pw), .pc_write_cond(a_pwc), .zero(a_zero),
      .exc_req(a_exc), .exc_code(a_code), .vec_data(a_vdata),
      .vec_rd(a_vrd), .vec_addr(a_vaddr), .pc(a_pc), .epc(a_epc),
      .exc_busy(a_busy), .exc_done(a_done)
   );

   pc_update_unit #(.WIDTH(32), .NSRC(5), .RESET_PC(32'h100), .VEC_BASE(253), .MEM_LAT(3)) dut_b (
      .clk(clk), .reset(b_rst), .src_sel(b_sel), .src_data(b_src),
      .pc_write(b_pw), .pc_write_cond(b_pwc), .zero(b_zero),
      .exc_req(b_exc), .exc_code(b_code), .vec_data(b_vdata),
      .vec_rd(b_vrd), .vec_addr(b_vaddr), .pc(b_pc), .epc(b_epc),
      .exc_busy(b_busy), .exc_done(b_done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Vector memory contents around the exception area
   function automatic logic [7:0] vec_byte(input int addr);
      case (addr)
         253:     return 8'h5A;
         254:     return 8'h7C;
         255:     return 8'h33;
         256:     return 8'hC1;
         default: return 8'hEE;
      endcase
   endfunction

   // Reference model: PC, EPC and the number of busy cycles left in an exception
   logic [31:0] m_pc[2], m_epc[2];
   int          m_busy[2];
   int          m_code[2];
   logic        m_done[2];
   int          req_cyc[2] = '{-100, -100};
   int          req_addr[2];

   function automatic int lat_of(input int i);   return (i == 0) ? 1 : 3;  endfunction
   function automatic int nsrc_of(input int i);  return (i == 0) ? 4 : 5;  endfunction
   function automatic logic [31:0] rpc_of(input int i); return (i == 0) ? 32'h0 : 32'h100; endfunction

   task automatic model_step(input int i, input logic rst, input int sel, input logic [31:0] selval,
                             input logic pw, input logic pwc, input logic z, input logic exc,
                             input logic [1:0] code);
      if (rst) begin
         m_pc[i] = rpc_of(i); m_epc[i] = 32'h0; m_busy[i] = 0; m_done[i] = 1'b0;
      end else begin
         m_done[i] = 1'b0;
         if (m_busy[i] > 0) begin
            if (m_busy[i] == 1) begin
               m_pc[i]   = {24'h0, vec_byte(253 + m_code[i])};
               m_done[i] = 1'b1;
            end
            m_busy[i]--;
         end else if (exc) begin
            m_epc[i]  = m_pc[i] - 32'd4;
            m_code[i] = int'(code);
            m_busy[i] = lat_of(i) + 1;
         end else if ((pw || (pwc && z)) && sel < nsrc_of(i)) begin
            m_pc[i] = selval;
         end
      end
   endtask

   task automatic model_check();
      chk("a_pc",    a_pc,    m_pc[0]);
      chk("a_epc",   a_epc,   m_epc[0]);
      chk("a_busy",  32'(a_busy), 32'(m_busy[0] > 0));
      chk("a_done",  32'(a_done), 32'(m_done[0]));
      chk("a_vrd",   32'(a_vrd),  32'(m_busy[0] == 2));
      chk("a_vaddr", a_vaddr, (m_busy[0] == 2) ? 32'(253 + m_code[0]) : 32'h0);
      chk("b_pc",    b_pc,    m_pc[1]);
      chk("b_epc",   b_epc,   m_epc[1]);
      chk("b_busy",  32'(b_busy), 32'(m_busy[1] > 0));
      chk("b_done",  32'(b_done), 32'(m_done[1]));
      chk("b_vrd",   32'(b_vrd),  32'(m_busy[1] == 4));
      chk("b_vaddr", b_vaddr, (m_busy[1] == 4) ? 32'(253 + m_code[1]) : 32'h0);
   endtask

   // One clock: memory answers MEM_LAT cycles after a read, model advances, edge, settle
   task automatic tick();
      logic [31:0] av, bv;
      if (a_vrd) begin req_cyc[0] = cyc; req_addr[0] = int'(a_vaddr); end
      if (b_vrd) begin req_cyc[1] = cyc; req_addr[1] = int'(b_vaddr); end
      a_vdata = (cyc == req_cyc[0] + 1) ? vec_byte(req_addr[0]) : 8'($urandom);
      b_vdata = (cyc == req_cyc[1] + 3) ? vec_byte(req_addr[1]) : 8'($urandom);
      av = a_src[int'(a_sel)*32 +: 32];
      bv = (b_sel < 3'd5) ? b_src[int'(b_sel)*32 +: 32] : 32'h0;
      model_step(0, a_rst, int'(a_sel), av, a_pw, a_pwc, a_zero, a_exc, a_code);
      model_step(1, b_rst, int'(b_sel), bv, b_pw, b_pwc, b_zero, b_exc, b_code);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_a();
      a_rst = 1'b0; a_pw = 1'b0; a_pwc = 1'b0; a_zero = 1'b0; a_exc = 1'b0;
      a_sel = 2'd0; a_code = 2'd0;
   endtask

   task automatic idle_b();
      b_rst = 1'b0; b_pw = 1'b0; b_pwc = 1'b0; b_zero = 1'b0; b_exc = 1'b0;
      b_sel = 3'd0; b_code = 2'd0;
   endtask

   task automatic load_b(input logic [2:0] sel, input logic [31:0] val);
      for (int k = 0; k < 5; k++) b_src[k*32 +: 32] = $urandom;
      b_sel = sel;
      if (sel < 3'd5) b_src[int'(sel)*32 +: 32] = val;
   endtask

   typedef struct {
      logic [31:0] rst, sel, val, pw, pwc, z, exc, code;
      logic [31:0] e_pc, e_epc, e_busy, e_done, e_vrd, e_vaddr;
   } row_t;

   row_t tbl[15];

   initial begin
      //           rst sel  val   pw pwc z exc code  pc          epc          busy done vrd vaddr
      tbl[0]  = '{1,  0,   0,    0, 0,  0, 0,  0,    0,          0,           0,   0,   0,  0};
      tbl[1]  = '{0,  2,   'h40, 1, 0,  0, 0,  0,    'h40,       0,           0,   0,   0,  0};
      tbl[2]  = '{0,  1,   'h80, 0, 1,  0, 0,  0,    'h40,       0,           0,   0,   0,  0};
      tbl[3]  = '{0,  1,   'h80, 0, 1,  1, 0,  0,    'h80,       0,           0,   0,   0,  0};
      tbl[4]  = '{0,  0,   'h24, 1, 0,  0, 0,  0,    'h24,       0,           0,   0,   0,  0};
      tbl[5]  = '{0,  0,   'h99, 1, 0,  0, 1,  1,    'h24,       'h20,        1,   0,   1,  254};
      tbl[6]  = '{0,  0,   'h55, 1, 0,  0, 1,  2,    'h24,       'h20,        1,   0,   0,  0};
      tbl[7]  = '{0,  0,   'h66, 1, 0,  0, 1,  0,    'h7C,       'h20,        0,   1,   0,  0};
      tbl[8]  = '{0,  0,   0,    0, 0,  0, 1,  3,    'h7C,       'h78,        1,   0,   1,  256};
      tbl[9]  = '{0,  0,   0,    0, 0,  0, 0,  0,    'h7C,       'h78,        1,   0,   0,  0};
      tbl[10] = '{0,  0,   0,    0, 0,  0, 0,  0,    'hC1,       'h78,        0,   1,   0,  0};
      tbl[11] = '{0,  0,   0,    1, 0,  0, 0,  0,    0,          'h78,        0,   0,   0,  0};
      tbl[12] = '{0,  0,   0,    0, 0,  0, 1,  0,    0,          'hFFFFFFFC,  1,   0,   1,  253};
      tbl[13] = '{1,  0,   0,    0, 0,  0, 1,  2,    0,          0,           0,   0,   0,  0};
      tbl[14] = '{0,  0,   0,    0, 0,  0, 0,  0,    0,          0,           0,   0,   0,  0};

      idle_a(); idle_b();
      a_src = '0; b_src = '0; a_vdata = 8'h0; b_vdata = 8'h0;
      @(negedge clk);

      // Directed table on build A; build B held in reset meanwhile
      b_rst = 1'b1;
      for (int i = 0; i < 15; i++) begin
         for (int k = 0; k < 4; k++) a_src[k*32 +: 32] = $urandom;
         a_rst  = tbl[i].rst[0];
         a_sel  = tbl[i].sel[1:0];
         a_src[int'(a_sel)*32 +: 32] = tbl[i].val;
         a_pw   = tbl[i].pw[0];
         a_pwc  = tbl[i].pwc[0];
         a_zero = tbl[i].z[0];
         a_exc  = tbl[i].exc[0];
         a_code = tbl[i].code[1:0];
         tick();
         chk($sformatf("t%0d_pc", i),    a_pc,         tbl[i].e_pc);
         chk($sformatf("t%0d_epc", i),   a_epc,        tbl[i].e_epc);
         chk($sformatf("t%0d_busy", i),  32'(a_busy),  tbl[i].e_busy);
         chk($sformatf("t%0d_done", i),  32'(a_done),  tbl[i].e_done);
         chk($sformatf("t%0d_vrd", i),   32'(a_vrd),   tbl[i].e_vrd);
         chk($sformatf("t%0d_vaddr", i), a_vaddr,      tbl[i].e_vaddr);
      end
      idle_a();

      // Build B: reset value, out-of-range select, MEM_LAT=3 timing, reset in VEC_WAIT
      b_rst = 1'b1; tick(); b_rst = 1'b0;
      chk("b_rst_pc", b_pc, 32'h100);
      chk("b_rst_epc", b_epc, 32'h0);
      chk("b_rst_busy", 32'(b_busy), 32'h0);
      load_b(3'd5, 32'h0); b_pw = 1'b1; tick();
      chk("b_oor_hold", b_pc, 32'h100);
      load_b(3'd4, 32'h24); tick();
      chk("b_ch4_load", b_pc, 32'h24);
      load_b(3'd0, 32'h99); b_exc = 1'b1; b_code = 2'd1; tick(); idle_b();
      chk("b_req_vrd", 32'(b_vrd), 32'h1);
      chk("b_req_vaddr", b_vaddr, 32'd254);
      chk("b_req_epc", b_epc, 32'h20);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("b_wait%0d_busy", k), 32'(b_busy), 32'h1);
         chk($sformatf("b_wait%0d_pc", k), b_pc, 32'h24);
         chk($sformatf("b_wait%0d_done", k), 32'(b_done), 32'h0);
      end
      tick();
      chk("b_vec_pc", b_pc, 32'h7C);
      chk("b_vec_done", 32'(b_done), 32'h1);
      chk("b_vec_busy", 32'(b_busy), 32'h0);
      load_b(3'd4, 32'h30); b_pw = 1'b1; tick(); idle_b();
      b_exc = 1'b1; b_code = 2'd2; tick(); idle_b();
      tick();
      chk("b_in_wait_busy", 32'(b_busy), 32'h1);
      chk("b_in_wait_epc", b_epc, 32'h2C);
      b_rst = 1'b1; tick(); b_rst = 1'b0;
      chk("b_abort_pc", b_pc, 32'h100);
      chk("b_abort_epc", b_epc, 32'h0);
      chk("b_abort_busy", 32'(b_busy), 32'h0);
      chk("b_abort_done", 32'(b_done), 32'h0);
      tick();
      chk("b_abort_nodone", 32'(b_done), 32'h0);
      chk("b_abort_pc2", b_pc, 32'h100);

      // Random traffic on both builds against the model
      a_rst = 1'b1; b_rst = 1'b1; tick();
      for (int n = 0; n < 800; n++) begin
         a_rst  = ($urandom_range(63) == 0);
         b_rst  = ($urandom_range(63) == 0);
         a_sel  = 2'($urandom);
         b_sel  = 3'($urandom);
         for (int k = 0; k < 4; k++) a_src[k*32 +: 32] = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
         for (int k = 0; k < 5; k++) b_src[k*32 +: 32] = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
         a_pw   = ($urandom_range(2) == 0);
         b_pw   = ($urandom_range(2) == 0);
         a_pwc  = ($urandom_range(2) == 0);
         b_pwc  = ($urandom_range(2) == 0);
         a_zero = 1'($urandom);
         b_zero = 1'($urandom);
         a_exc  = ($urandom_range(5) == 0);
         b_exc  = ($urandom_range(5) == 0);
         a_code = 2'($urandom);
         b_code = 2'($urandom);
         tick();
         model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_update_unit.md
# pc_update_unit

Parametrised program-counter update unit for the multicycle datapath. It selects the next PC from NSRC target channels and supports both unconditional and branch-conditional writes. It also runs the exception entry sequence: it captures EPC, reads the one-byte handler address from the exception vector area of memory, and loads it into PC. It sits between the control unit, the ALU/shift/EPC outputs that feed PC targets, and the memory address mux, which it drives during vector fetch.

## Interface
Parameters:
- WIDTH, 32, PC/EPC/target width
- NSRC, 4, number of PC target channels (≥2); SEL_W = $clog2(NSRC) is derived, not overridable
- RESET_PC, 0, PC value after reset
- VEC_BASE, 253, memory address of exception vector for code 0
- MEM_LAT, 1, cycles from vec_rd cycle to vec_data valid (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- src_sel  in  SEL_W  target channel select
- src_data  in  NSRC*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  PC load qualified by zero
- zero  in  1  ALU zero flag (branch condition)
- exc_req  in  1  exception request (single-cycle level sampled)
- exc_code  in  2  0 = bad opcode, 1 = overflow, 2 = divide-by-zero, 3 = reserved
- vec_data  in  8  byte read from memory
- vec_rd  out  1  memory read request for vector byte
- vec_addr  out  WIDTH  vector address, valid while vec_rd
- pc  out  WIDTH  current PC (registered)
- epc  out  WIDTH  exception PC (registered)
- exc_busy  out  1  high while exception sequence active
- exc_done  out  1  one-cycle pulse, first cycle new handler PC is visible

## Operation
- States: RUN, VEC_REQ, VEC_WAIT, VEC_LOAD.
- RUN: load = pc_write | (pc_write_cond & zero). On load, pc ← src_data channel src_sel. If src_sel ≥ NSRC, pc holds.
- RUN with exc_req=1: exception wins over any load that cycle. epc ← pc − 4 (modulo 2^WIDTH). Code is latched. Next state VEC_REQ.
- VEC_REQ (1 cycle): vec_rd=1, vec_addr = VEC_BASE + latched code (zero-extended, modulo 2^WIDTH). Next state VEC_WAIT, latency counter cleared.
- VEC_WAIT: counter increments each cycle. It exits to VEC_LOAD after MEM_LAT−1 cycles; with MEM_LAT=1 it is skipped straight to VEC_LOAD.
- VEC_LOAD: vec_data is sampled. pc ← {(WIDTH−8) zeros, vec_data}. State returns to RUN. exc_done registered high for the following cycle.
- exc_busy = (state ≠ RUN). While busy, pc_write, pc_write_cond and exc_req are ignored; nested exceptions are dropped, not queued.
- vec_rd and vec_addr are 0 outside VEC_REQ.
- Reset: pc=RESET_PC, epc=0, state RUN, vec_rd=0, vec_addr=0, exc_busy=0, exc_done=0. Reset mid-sequence abandons it. The vector is not loaded and the epc write already made is cleared.
- epc is written only on exception entry. It is never altered by normal loads.

## Timing
- Normal load: src_data sampled at edge E, new pc visible the cycle after E. Latency 1.
- Exception: exc_req sampled at edge E0, so VEC_REQ is the cycle after E0.
- pc is loaded with the vector at edge E0+MEM_LAT+1.
- exc_done and exc_busy=0 appear in the same cycle the new pc is visible.
- The sequence occupies MEM_LAT+1 busy cycles.
- Back-to-back: an exc_req in the exc_done cycle is accepted (state already RUN).
- exc_req and reset in the same cycle: reset wins.

## Structure
- Shared header pc_unit_defs: state encoding localparams (RUN=0, VEC_REQ=1, VEC_WAIT=2, VEC_LOAD=3) and exception code constants. The control unit uses the same code constants.
- One sub-module: pc_src_mux_n, a generic NSRC×WIDTH combinational selector with out-of-range flag. It is reusable by the other datapath muxes.
- Counter width $clog2(MEM_LAT+1).

## Test plan
- Reset then src_sel=2, ch2=0x40, pc_write=1 → pc=0x40 next cycle. With RESET_PC=0x100, pc=0x100 after reset.
- pc_write_cond=1, ch1=0x80: zero=0 → pc unchanged; zero=1 → pc=0x80. src_sel=NSRC (NSRC=5 build) → pc holds.
- pc=0x24, exc_req=1, code=1, pc_write=1 same cycle → epc=0x20, vec_rd pulse with vec_addr=254; vec_data=0x7C → pc=0x7C with exc_done at E0+2 (MEM_LAT=1). Repeat with MEM_LAT=3 → load at E0+4.
- pc=0 exception → epc=0xFFFFFFFC (wrap). exc_code=3 → vec_addr=256.
- exc_req and pc_write pulsed while exc_busy → ignored, pc and epc unchanged until exc_done. exc_req in the exc_done cycle → new sequence starts.
- reset asserted in VEC_WAIT → next cycle pc=RESET_PC, epc=0, exc_busy=0, no exc_done.
